my_sr: RTL and testbench

8-bit maximal-length Fibonacci LFSR that emits one pseudo-random bit per clock on `Dout`. `SEED` sets the starting state. The block is a stand-alone PRBS source for bit-serial test stimulus and scramblers. It is a single clock domain with no handshake: the output is valid every cycle once reset is released.

---
 rtl/my_sr_pkg.sv | 21 ++
 rtl/my_sr_fb.sv | 19 +
 rtl/my_sr.sv | 58 +++++
 tb/tb_my_sr.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/my_sr_pkg.sv
// Shared constants, state type and reference next-state function for the my_sr PRBS source.
package my_sr_pkg;

  localparam int unsigned SR_WIDTH = 8;

  typedef logic [SR_WIDTH-1:0] sr_state_t;

  localparam sr_state_t SR_TAPS     = 8'hB8;
  localparam sr_state_t SR_ZERO_SUB = 8'h01;

  // Next LFSR state; an all-zero state recovers to SR_ZERO_SUB instead of locking up.
  function automatic sr_state_t sr_next(input sr_state_t state, input sr_state_t taps);
    logic fb;
    if (state == '0) begin
      return SR_ZERO_SUB;
    end
    fb = ^(state & taps);
    return {state[SR_WIDTH-2:0], fb};
  endfunction

endpackage

// File: rtl/my_sr_fb.sv
// Feedback bit of the Fibonacci LFSR: parity of the tapped state bits.
module my_sr_fb
  import my_sr_pkg::*;
#(
  parameter int unsigned           WIDTH = SR_WIDTH,
  parameter logic [WIDTH-1:0]      TAPS  = SR_TAPS
) (
  input  logic [WIDTH-1:0] state_i,
  output logic             fb_o
);

  logic [WIDTH-1:0] tapped;

  always_comb begin
    tapped = state_i & TAPS;
    fb_o   = ^tapped;
  end

endmodule

// File: rtl/my_sr.sv
// 8-bit maximal-length Fibonacci LFSR emitting one PRBS bit per clock, with zero-seed
// substitution and an all-zero lock-up guard.
module my_sr
  import my_sr_pkg::*;
#(
  parameter int unsigned      WIDTH    = SR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = SR_TAPS,
  parameter logic [WIDTH-1:0] ZERO_SUB = SR_ZERO_SUB
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SEED,
  output logic             Dout
);

  if (WIDTH < 2) begin : g_chk_width
    $error("my_sr: WIDTH must be at least 2");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_chk_taps
    $error("my_sr: TAPS must include the MSB");
  end
  if (ZERO_SUB == '0) begin : g_chk_zero_sub
    $error("my_sr: ZERO_SUB must be nonzero");
  end

  logic [WIDTH-1:0] seed_ok;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             fb;
  logic             locked_up;

  assign seed_ok = (SEED == '0) ? ZERO_SUB : SEED;

  my_sr_fb #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_fb (
    .state_i (state_q),
    .fb_o    (fb)
  );

  always_comb begin
    locked_up = (state_q == '0);
    state_d   = locked_up ? ZERO_SUB : {state_q[WIDTH-2:0], fb};
  end

  // Asynchronous seed load: state follows seed_ok for as long as RST is high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= seed_ok;
    end else begin
      state_q <= state_d;
    end
  end

  assign Dout = state_q[WIDTH-1];

endmodule

// File: tb/tb_my_sr.sv
// Self-checking bench for my_sr against a tap-counting LFSR model.
module tb_my_sr;
  import my_sr_pkg::*;

  logic       CLK;
  logic       RST;
  logic [7:0] SEED;
  logic       Dout;

  int checks = 0;
  int errors = 0;

  my_sr dut (
    .CLK  (CLK),
    .RST  (RST),
    .SEED (SEED),
    .Dout (Dout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: feedback is 1 when an odd number of bits 7,5,4,3 are set; zero recovers to 1.
  function automatic int model_next(input int s);
    int n;
    if (s == 0) return 1;
    n = 0;
    if ((s / 128) % 2 == 1) n++;
    if ((s / 32) % 2 == 1) n++;
    if ((s / 16) % 2 == 1) n++;
    if ((s / 8) % 2 == 1) n++;
    return ((s * 2) % 256) + (n % 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int exp);
    check({tag, "_state"}, 32'(dut.state_q), 32'(exp));
    check({tag, "_dout"}, 32'(Dout), 32'((exp / 128) % 2));
  endtask

  initial begin
    int m;
    int period;
    int ones;
    int zero_seen;
    int first5 [5];
    first5 = '{8'h8E, 8'h1C, 8'h38, 8'h71, 8'hE2};

    // Reset hold
    SEED = 8'h47;
    RST  = 1'b1;
    #1;
    check_state("rst_immediate", 8'h47);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_state("rst_hold", 8'h47);
    end

    // Release and run 600 clocks against the model, measuring period and ones count
    RST = 1'b0;
    m = 8'h47;
    period = 0;
    ones = 0;
    zero_seen = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge CLK);
      m = model_next(m);
      check_state("seq", m);
      if (i <= 5) check("seq_first5", 32'(dut.state_q), 32'(first5[i-1]));
      if (i <= 255 && Dout === 1'b1) ones++;
      if (dut.state_q == 8'h00) zero_seen++;
      if (period == 0 && dut.state_q == 8'h47) period = i;
      if (i == 300) SEED = 8'hC3;  // SEED changes while running must be ignored
    end
    check("period", 32'(period), 32'd255);
    check("ones_per_period", 32'(ones), 32'd128);
    check("zero_never", 32'(zero_seen), 32'd0);
    check("pkg_sr_next", 32'(sr_next(8'h38, SR_TAPS)), 32'(model_next(8'h38)));

    // Async reset mid-run at cycle 37, between edges
    SEED = 8'h47;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    m = 8'h47;
    for (int i = 0; i < 37; i++) begin
      @(negedge CLK);
      m = model_next(m);
    end
    check_state("pre_abort", m);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check_state("abort_immediate", 8'h47);
    @(negedge CLK);
    check_state("abort_hold", 8'h47);
    RST = 1'b0;
    @(negedge CLK);
    check_state("abort_restart", 8'h8E);

    // Zero seed substitution
    SEED = 8'h00;
    RST  = 1'b1;
    #1;
    check_state("zero_seed_rst", 8'h01);
    @(negedge CLK);
    RST = 1'b0;
    m = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      m = model_next(m);
      check_state("zero_seed_seq", m);
      if (i == 0) check("zero_seed_02", 32'(dut.state_q), 32'h02);
      if (i == 3) check("zero_seed_11", 32'(dut.state_q), 32'h11);
    end

    // Lock-up guard: corrupt the state to zero between edges
    force dut.state_q = 8'h00;
    #1;
    release dut.state_q;
    #1;
    check("lockup_forced", 32'(dut.state_q), 32'h00);
    @(negedge CLK);
    check_state("lockup_recover", 8'h01);
    m = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      m = model_next(m);
      check_state("lockup_after", m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
